// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a load/store unit and data_mem_ctrl.
// The master drives the request fields; the slave returns ready, the load response and the fault flag.
interface data_mem_ctrl_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        fault;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  ready, rvalid, rdata, fault
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output ready, rvalid, rdata, fault
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory controller: word RAM with byte/half/word access, and memory-mapped LED, BCD and cycle-counter registers.
// After reset the RAM is swept to zero before any request is accepted.
module data_mem_ctrl #(
    parameter int          ADDR_BITS = 8,
    parameter logic [31:0] MMIO_BASE = 32'h4000_0000
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_ctrl_if.slave bus,
    output logic           busy,
    output logic [7:0]     led,
    output logic [11:0]    bcd
);
    localparam int DEPTH = 2**ADDR_BITS;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ADDR_BITS-1:0] index;
    logic [ADDR_BITS-1:0] index_nxt;
    logic                 clr_we;
    logic                 ready;

    logic [31:0]          mem [DEPTH];

    logic                 rvalid_q;
    logic [31:0]          rdata_q;
    logic                 fault_q;
    logic [31:0]          counter;

    logic                 accept;
    logic                 in_ram;
    logic                 in_mmio;
    logic [31:0]          mmio_off;
    logic [ADDR_BITS-1:0] widx;
    logic                 misalign;
    logic                 bad_access;
    logic                 store_ram;
    logic                 store_mmio;
    logic [3:0]           lane_mask;
    logic [31:0]          wdata_rep;
    logic [31:0]          ram_word;
    logic [31:0]          shifted;
    logic [31:0]          load_ram;
    logic [31:0]          load_mmio;
    logic [31:0]          load_val;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CLEAR;
            index <= '0;
        end else begin
            state <= state_nxt;
            index <= index_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        index_nxt = index;
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we    = 1'b1;
                index_nxt = index + 1'b1;
                if (index == {ADDR_BITS{1'b1}}) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = CLEAR;
                index_nxt = '0;
            end
        endcase
    end

    assign ready     = (state == IDLE);
    assign busy      = (state == CLEAR);
    assign bus.ready = ready;

    // ------------------------------------------------------------------
    // Address decode and fault classification
    // ------------------------------------------------------------------
    assign accept   = bus.req && ready;
    assign in_ram   = ((bus.addr >> (ADDR_BITS + 2)) == 32'd0);
    assign mmio_off = bus.addr - MMIO_BASE;
    // Any byte inside the three register words counts as MMIO so that
    // misaligned or narrow accesses there are reported as faults.
    assign in_mmio  = !in_ram && (mmio_off < 32'd12);
    assign widx     = bus.addr[ADDR_BITS+1:2];

    always_comb begin
        misalign = 1'b0;
        case (bus.size)
            2'd1:    misalign = bus.addr[0];
            2'd2:    misalign = (bus.addr[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
    end

    assign bad_access = (bus.size == 2'd3) || misalign ||
                        (!in_ram && !in_mmio) ||
                        (in_mmio && (bus.size != 2'd2));

    assign store_ram  = accept && bus.we && !bad_access && in_ram;
    assign store_mmio = accept && bus.we && !bad_access && in_mmio;

    // ------------------------------------------------------------------
    // Store lane steering
    // ------------------------------------------------------------------
    always_comb begin
        lane_mask = 4'b1111;
        wdata_rep = bus.wdata;
        case (bus.size)
            2'd0: begin
                lane_mask = 4'b0001 << bus.addr[1:0];
                wdata_rep = {4{bus.wdata[7:0]}};
            end
            2'd1: begin
                lane_mask = bus.addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{bus.wdata[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                wdata_rep = bus.wdata;
            end
        endcase
    end

    // RAM has no reset; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[index] <= 32'h0;
        end else if (store_ram) begin
            for (int l = 0; l < 4; l++) begin
                if (lane_mask[l]) begin
                    mem[widx][8*l +: 8] <= wdata_rep[8*l +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load data formatting
    // ------------------------------------------------------------------
    assign ram_word = mem[widx];
    assign shifted  = ram_word >> {bus.addr[1:0], 3'b000};

    always_comb begin
        load_ram = ram_word;
        case (bus.size)
            2'd0:    load_ram = {{24{bus.sign_ext & shifted[7]}}, shifted[7:0]};
            2'd1:    load_ram = {{16{bus.sign_ext & shifted[15]}}, shifted[15:0]};
            default: load_ram = ram_word;
        endcase
    end

    always_comb begin
        load_mmio = counter;
        case (mmio_off[3:2])
            2'd0:    load_mmio = {24'h0, led};
            2'd1:    load_mmio = {20'h0, bcd};
            default: load_mmio = counter;
        endcase
    end

    assign load_val = bad_access ? 32'h0 : (in_ram ? load_ram : load_mmio);

    // ------------------------------------------------------------------
    // Response, fault, peripheral registers, free-running counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            fault_q  <= 1'b0;
            led      <= 8'h0;
            bcd      <= 12'h0;
            counter  <= 32'h0;
        end else begin
            counter  <= counter + 32'd1;
            rvalid_q <= accept && !bus.we;
            if (accept && !bus.we) begin
                rdata_q <= load_val;
            end
            if (accept && bad_access) begin
                fault_q <= 1'b1;
            end
            // Stores to the counter word are silently dropped.
            if (store_mmio && (mmio_off[3:2] == 2'd0)) begin
                led <= bus.wdata[7:0];
            end
            if (store_mmio && (mmio_off[3:2] == 2'd1)) begin
                bcd <= bus.wdata[11:0];
            end
        end
    end

    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.fault  = fault_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl with a 16-word RAM: load responses are
// matched in order against expectations queued when each load is driven.
module tb_data_mem_ctrl;
    localparam int          AB = 4;
    localparam logic [31:0] MB = 32'h4000_0000;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        busy;
    logic [7:0]  led;
    logic [11:0] bcd;

    data_mem_ctrl_if bus ();

    data_mem_ctrl #(
        .ADDR_BITS (AB),
        .MMIO_BASE (MB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .led   (led),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_last = 32'h0;
    logic [31:0] cyc;

    // Reference cycle count since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 32'h0;
        else        cyc <= cyc + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            exp_last = 32'h0;
        end else if (bus.rvalid) begin
            if (exp_q.size() == 0) begin
                chk("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                exp_last = exp_q.pop_front();
                chk("rdata", bus.rdata, exp_last);
            end
        end else begin
            chk("rdata_hold", bus.rdata, exp_last);
        end
    end

    task automatic acc(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
        @(negedge clk);
        bus.req      = 1'b1;
        bus.we       = w;
        bus.size     = sz;
        bus.sign_ext = sx;
        bus.addr     = a;
        bus.wdata    = d;
        if (!w) exp_q.push_back(e);
    endtask

    task automatic ld_cnt();
        @(negedge clk);
        bus.req      = 1'b1;
        bus.we       = 1'b0;
        bus.size     = 2'd2;
        bus.sign_ext = 1'b0;
        bus.addr     = MB + 32'd8;
        bus.wdata    = 32'h0;
        exp_q.push_back(cyc);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    task automatic wait_ready(input int start);
        int cnt;
        cnt = start;
        while (!bus.ready && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("clear_cycles", cnt, 16);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy",   busy,       1);
        chk("rst_ready",  bus.ready,  0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rdata",  bus.rdata,  0);
        chk("rst_fault",  bus.fault,  0);
        chk("rst_led",    led,        0);
        chk("rst_bcd",    bcd,        0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.req      = 1'b0;
        bus.we       = 1'b0;
        bus.size     = 2'd0;
        bus.sign_ext = 1'b0;
        bus.addr     = 32'h0;
        bus.wdata    = 32'h0;

        #12;
        chk_reset_outputs();
        @(negedge clk);
        #1 reset = 1'b1;
        wait_ready(0);

        acc(0, 2'd2, 0, 32'h00, 0, 32'h0);
        acc(0, 2'd2, 0, 32'h3C, 0, 32'h0);

        acc(1, 2'd2, 0, 32'h0, 32'h8765_43A1, 0);
        acc(0, 2'd0, 1, 32'h0, 0, 32'hFFFF_FFA1);
        acc(0, 2'd1, 0, 32'h2, 0, 32'h0000_8765);
        acc(0, 2'd1, 1, 32'h2, 0, 32'hFFFF_8765);
        acc(0, 2'd0, 0, 32'h3, 0, 32'h0000_0087);
        acc(0, 2'd0, 1, 32'h1, 0, 32'h0000_0043);

        acc(1, 2'd2, 0, 32'h4, 32'h1111_1111, 0);
        acc(1, 2'd0, 0, 32'h5, 32'h0000_005A, 0);
        acc(0, 2'd2, 0, 32'h4, 0, 32'h1111_5A11);
        acc(1, 2'd1, 0, 32'h6, 32'h0000_BEEF, 0);
        acc(0, 2'd2, 0, 32'h4, 0, 32'hBEEF_5A11);

        acc(1, 2'd2, 0, MB,          32'h0000_01FF, 0);
        acc(1, 2'd2, 0, MB + 32'd4,  32'h0000_0123, 0);
        acc(1, 2'd2, 0, MB + 32'd8,  32'hDEAD_BEEF, 0);
        idle();
        chk("led", led, 32'hFF);
        chk("bcd", bcd, 32'h123);
        chk("fault_clean", bus.fault, 0);
        acc(0, 2'd2, 0, MB,         0, 32'h0000_00FF);
        acc(0, 2'd2, 0, MB + 32'd4, 0, 32'h0000_0123);
        ld_cnt();
        ld_cnt();
        idle();

        acc(1, 2'd1, 0, 32'h1, 32'h0000_FFFF, 0);
        idle();
        chk("fault_half_mis", bus.fault, 1);
        acc(0, 2'd2, 0, 32'h0,   0, 32'h8765_43A1);
        acc(0, 2'd2, 0, 32'h7FF, 0, 32'h0);
        acc(0, 2'd2, 0, 32'h100, 0, 32'h0);
        idle();
        chk("fault_sticky", bus.fault, 1);

        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_outputs();
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("rst_mid_busy", busy, 1);
        @(negedge clk);
        #1 reset = 1'b1;
        // Requests while the sweep runs must be ignored.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd2; bus.addr = 32'h0; bus.wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.addr = MB; bus.wdata = 32'h0000_00AA;
        @(negedge clk);
        bus.we = 1'b0; bus.addr = 32'h4;
        @(negedge clk);
        bus.req = 1'b0;
        wait_ready(4);

        acc(0, 2'd2, 0, 32'h00, 0, 32'h0);
        acc(0, 2'd2, 0, 32'h04, 0, 32'h0);
        acc(0, 2'd2, 0, 32'h3C, 0, 32'h0);
        acc(0, 2'd2, 0, MB,     0, 32'h0);
        idle();
        chk("post_rst_fault", bus.fault, 0);
        chk("post_rst_led",   led,       0);
        chk("post_rst_bcd",   bcd,       0);

        acc(1, 2'd0, 0, MB, 32'h0000_0055, 0);
        idle();
        chk("fault_mmio_byte", bus.fault, 1);
        chk("led_unchanged",   led,       0);
        acc(0, 2'd3, 0, 32'h0, 0, 32'h0);
        idle();

        repeat (3) @(negedge clk);
        chk("pending", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, word-index width; RAM depth = 2**ADDR_BITS 32-bit words.
REQ-002 SHALL have parameter MMIO_BASE, default 32'h4000_0000, byte base address of peripheral registers.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  access request, accepted when req&ready at rising edge.
REQ-006 SHALL have port we  input  1  1=store, 0=load.
REQ-007 SHALL have port size  input  2  0=byte, 1=half, 2=word, 3=illegal.
REQ-008 SHALL have port sign_ext  input  1  loads only: 1=sign-extend, 0=zero-extend.
REQ-009 SHALL have port addr  input  32  byte address.
REQ-010 SHALL have port wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port ready  output  1  block can accept a request this cycle.
REQ-012 SHALL have port busy  output  1  post-reset clear sweep in progress.
REQ-013 SHALL have port rvalid  output  1  one-cycle load-response pulse.
REQ-014 SHALL have port rdata  output  32  load data, right-aligned and extended.
REQ-015 SHALL have port fault  output  1  sticky error flag.
REQ-016 SHALL have port led  output  8  LED register.
REQ-017 SHALL have port bcd  output  12  three-digit BCD display register.

Function
REQ-018 SHALL implement FSM states CLEAR and IDLE; reset enters CLEAR with sweep index 0.
REQ-019 In CLEAR SHALL write 32'h0 to word[index] each cycle, index+1; after word 2**ADDR_BITS-1 SHALL go to IDLE (clear takes exactly 2**ADDR_BITS cycles).
REQ-020 In CLEAR SHALL hold busy=1, ready=0; in IDLE busy=0, ready=1; req during CLEAR SHALL be ignored.
REQ-021 Byte order SHALL be little-endian: byte lane n (addr[1:0]=n) occupies bits 8n+7:8n.
REQ-022 RAM region SHALL be addr < 4*2**ADDR_BITS; word index = addr[ADDR_BITS+1:2].
REQ-023 Accepted store SHALL update only addressed lanes at the accepting edge: byte=1 lane, half=lanes addr[1]*2..+1, word=all four.
REQ-024 Accepted load SHALL produce rvalid=1 and rdata on the cycle after acceptance (latency 1); back-to-back loads SHALL be accepted every cycle.
REQ-025 Load data SHALL be selected lane(s) shifted to bit 0, upper bits filled with sign bit if sign_ext=1 else 0; sign_ext ignored for word.
REQ-026 A store accepted at edge N SHALL be visible to a load accepted at edge N+1.
REQ-027 MMIO_BASE+0 SHALL be LED (RW, bits[7:0], read upper bits 0); +4 BCD (RW, bits[11:0]); +8 cycle counter (RO, 32-bit, stores ignored without fault).
REQ-028 Cycle counter SHALL increment every clk from reset release, including CLEAR, wrapping 32'hFFFF_FFFF -> 0.
REQ-029 Fault conditions: size=3; half with addr[0]=1; word with addr[1:0]!=0; MMIO access with size!=2; address outside RAM and outside MMIO_BASE..MMIO_BASE+8.
REQ-030 Faulting access SHALL change no RAM/register state and SHALL set fault=1 at the accepting edge; faulting load SHALL still return rvalid=1, rdata=0.
REQ-031 fault SHALL remain 1 until reset.
REQ-032 rdata SHALL hold last value while rvalid=0.

Reset
REQ-033 reset=0 SHALL immediately force: state CLEAR, index 0, ready=0, busy=1, rvalid=0, rdata=0, fault=0, led=0, bcd=0, counter=0.
REQ-034 Reset asserted mid-CLEAR or mid-operation SHALL abort and restart the sweep at index 0; pending load response SHALL be discarded.

Verification
REQ-035 ADDR_BITS=4, release reset -> busy=1 for exactly 16 cycles, then ready=1; load any word -> 0.
REQ-036 Store word 0x8765_43A1 @0x0, then load byte @0x0 sign_ext=1 -> 0xFFFF_FFA1; half @0x2 sign_ext=0 -> 0x0000_8765.
REQ-037 Store byte 0x5A @0x5 over word 0x1111_1111 @0x4 -> load word @0x4 returns 0x1111_5A11.
REQ-038 Store half @0x1 -> fault=1, RAM unchanged; load word @0x7FF (out of range) -> rvalid=1, rdata=0, fault stays 1.
REQ-039 Store 0x1FF to MMIO_BASE+0 -> led=0xFF; store 0x123 to MMIO_BASE+4 -> bcd=0x123; two loads of MMIO_BASE+8 one cycle apart differ by 1.
REQ-040 Assert reset during CLEAR and after writes -> outputs at reset values, sweep restarts, prior data reads back 0.
